// File: rtl/ov7670_cfg_sequencer_if.sv
// Request/done handshake between the OV7670 table sequencer and the SCCB
// three-phase byte-write engine. The sequencer is the master side.
interface ov7670_cfg_sequencer_if;
    logic       wr_req;
    logic [7:0] wr_dev;
    logic [7:0] wr_reg;
    logic [7:0] wr_dat;
    logic       wr_done;
    logic       wr_nack;

    modport master (
        output wr_req,
        output wr_dev,
        output wr_reg,
        output wr_dat,
        input  wr_done,
        input  wr_nack
    );

    modport slave (
        input  wr_req,
        input  wr_dev,
        input  wr_reg,
        input  wr_dat,
        output wr_done,
        output wr_nack
    );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 bring-up sequencer: walks a (register, value) table, hands each
// pair to the SCCB write engine, retries NACKed writes, inserts a settle
// delay after a soft-reset write (COM7 bit 7) and reports finish/error.
module ov7670_cfg_sequencer #(
    parameter int         TABLE_LEN       = 16,
    parameter logic [7:0] DEV_ADDR        = 8'h42,
    parameter int         RESET_DELAY_CYC = 1000,
    parameter int         MAX_RETRY       = 3
) (
    input  logic                          clk_in,
    input  logic                          rst,
    input  logic                          in_flag,
    output logic [7:0]                    tab_addr,
    input  logic [15:0]                   tab_data,
    ov7670_cfg_sequencer_if.master        wr_if,
    output logic                          busy,
    output logic                          finish,
    output logic                          error,
    output logic [7:0]                    err_addr
);

    localparam logic [7:0]  LAST_ADDR  = 8'(TABLE_LEN - 1);
    localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [31:0] DELAY_LAST = 32'(RESET_DELAY_CYC - 1);
    localparam logic [15:0] END_MARKER = 16'hFFFF;
    localparam logic [7:0]  COM7_REG   = 8'h12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_REISSUE = 3'd3,
        S_DELAY   = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    state_t      r_state;
    logic        r_in_flag_d;
    logic [7:0]  r_tab_addr;
    logic        r_wr_req;
    logic [7:0]  r_wr_reg;
    logic [7:0]  r_wr_dat;
    logic        r_busy;
    logic        r_finish;
    logic        r_error;
    logic [7:0]  r_err_addr;
    logic [7:0]  r_retry_cnt;
    logic [31:0] r_delay_cnt;

    logic        w_start;
    logic        w_soft_reset;

    // Rising edge of the start request; a held-high in_flag starts only once.
    assign w_start      = in_flag & ~r_in_flag_d;
    // A COM7 write with bit 7 set resets the sensor and needs settle time.
    assign w_soft_reset = (r_wr_reg == COM7_REG) & r_wr_dat[7];

    assign tab_addr      = r_tab_addr;
    assign busy          = r_busy;
    assign finish        = r_finish;
    assign error         = r_error;
    assign err_addr      = r_err_addr;
    assign wr_if.wr_req  = r_wr_req;
    assign wr_if.wr_dev  = DEV_ADDR;
    assign wr_if.wr_reg  = r_wr_reg;
    assign wr_if.wr_dat  = r_wr_dat;

    // Sequencer FSM with all outputs held in registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_flag_d <= 1'b0;
            r_tab_addr  <= 8'd0;
            r_wr_req    <= 1'b0;
            r_wr_reg    <= 8'd0;
            r_wr_dat    <= 8'd0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_error     <= 1'b0;
            r_err_addr  <= 8'd0;
            r_retry_cnt <= 8'd0;
            r_delay_cnt <= 32'd0;
        end else begin
            r_in_flag_d <= in_flag;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (w_start) begin
                        r_state     <= S_FETCH;
                        r_tab_addr  <= 8'd0;
                        r_busy      <= 1'b1;
                        r_finish    <= 1'b0;
                        r_error     <= 1'b0;
                        r_retry_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (tab_data == END_MARKER) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                    end else begin
                        r_wr_reg <= tab_data[15:8];
                        r_wr_dat <= tab_data[7:0];
                        r_wr_req <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wr_if.wr_done) begin
                        r_wr_req <= 1'b0;
                        if (!wr_if.wr_nack) begin
                            if (w_soft_reset) begin
                                r_delay_cnt <= 32'd0;
                                r_state     <= S_DELAY;
                            end else begin
                                r_state <= S_NEXT;
                            end
                        end else if (r_retry_cnt < RETRY_MAX) begin
                            r_retry_cnt <= r_retry_cnt + 8'd1;
                            r_state     <= S_REISSUE;
                        end else begin
                            r_err_addr <= r_tab_addr;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                            r_finish   <= 1'b0;
                            r_state    <= S_FAIL;
                        end
                    end
                end
                S_REISSUE: begin
                    r_wr_req <= 1'b1;
                    r_state  <= S_WAIT;
                end
                S_DELAY: begin
                    if (r_delay_cnt == DELAY_LAST) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 32'd1;
                    end
                end
                S_NEXT: begin
                    r_retry_cnt <= 8'd0;
                    if (r_tab_addr == LAST_ADDR) begin
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tab_addr <= r_tab_addr + 8'd1;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_wr_req <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ov7670_cfg_sequencer.md
# ov7670_cfg_sequencer

Register-table sequencer for OV7670 camera bring-up. It walks a configuration table of (register, value) pairs and issues each one to an SCCB three-phase write engine over a request/done handshake. It retries NACKed writes, waits for the sensor to settle after a soft reset, and reports completion through `finish`. It sits between the system start pulse and the SCCB byte-write engine that drives `sccb_scl`/`sccb_sdl`.

## Interface
- `TABLE_LEN`, 16: number of table entries, 1..256.
- `DEV_ADDR`, 8'h42: SCCB write ID driven on `wr_dev`.
- `RESET_DELAY_CYC`, 1000: idle cycles inserted after a soft-reset write; minimum 1.
- `MAX_RETRY`, 3: extra attempts per entry after a NACK; 0 disables retries.

- `clk_in`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_flag`, in, 1: start request. The rising edge starts the sequence.
- `tab_addr`, out, 8: table entry index.
- `tab_data`, in, 16: entry at `tab_addr`, combinational ROM, valid in the same cycle. Bits [15:8] are the register, bits [7:0] the value.
- `wr_req`, out, 1: write request to the SCCB engine.
- `wr_dev`, out, 8: constant `DEV_ADDR`.
- `wr_reg`, out, 8: register address, stable while `wr_req`=1.
- `wr_dat`, out, 8: register value, stable while `wr_req`=1.
- `wr_done`, in, 1: one-cycle pulse from the engine when the write ends.
- `wr_nack`, in, 1: sampled with `wr_done`; 1 means the slave did not acknowledge.
- `busy`, out, 1: sequence in progress.
- `finish`, out, 1: whole table written successfully.
- `error`, out, 1: an entry failed after all retries.
- `err_addr`, out, 8: index of the failing entry.

## Operation
- Reset values: `tab_addr`=0, `wr_req`=0, `wr_reg`=0, `wr_dat`=0, `busy`=0, `finish`=0, `error`=0, `err_addr`=0. Internal state is IDLE, the retry counter is 0 and the delay counter is 0.
- Start detection: `in_flag` is registered into `in_flag_d`; `start = in_flag & ~in_flag_d`. A held-high `in_flag` starts exactly one sequence.
- **IDLE / DONE / FAIL**: on `start`, go to FETCH and set `tab_addr`=0, `busy`=1, `finish`=0, `error`=0, retry counter = 0.
- **FETCH** (1 cycle):
  - If `tab_data`==16'hFFFF (end marker), go to DONE.
  - Otherwise latch `wr_reg`/`wr_dat` from `tab_data` and go to WAIT with `wr_req`=1.
- **WAIT**:
  - `wr_req` stays 1 until `wr_done` is sampled. It is 0 from the next cycle.
  - On `wr_done` & !`wr_nack`:
    - If `wr_reg`==8'h12 and `wr_dat[7]`=1 (soft reset), go to DELAY.
    - Otherwise go to NEXT.
  - On `wr_done` & `wr_nack`:
    - If retry counter < `MAX_RETRY`, increment it and go to REISSUE.
    - Otherwise set `err_addr`=`tab_addr` and go to FAIL.
- **REISSUE** (1 cycle, `wr_req`=0): go to WAIT with `wr_req`=1. `wr_reg`/`wr_dat` are unchanged.
- **DELAY**: count `RESET_DELAY_CYC` cycles, then go to NEXT.
- **NEXT** (1 cycle):
  - Clear the retry counter.
  - If `tab_addr`==`TABLE_LEN`-1, go to DONE.
  - Otherwise increment `tab_addr` and go to FETCH.
- **DONE**: `busy`=0, `finish`=1. Both are held until the next `start`.
- **FAIL**: `busy`=0, `error`=1, `finish`=0. All are held until the next `start`.
- `start` in FETCH/WAIT/REISSUE/DELAY/NEXT is ignored. There is no abort.
- `wr_done` outside WAIT is ignored.
- Reset asserted mid-write returns all outputs to reset values immediately. The engine must reset on the same `rst`.

## Timing
- Start to first `wr_req`: the `start` edge enters FETCH, and `wr_req`=1 on the second edge after the `in_flag` rise is sampled.
- Per entry, no retry, no delay: engine latency + 3 cycles (WAIT exit, NEXT, FETCH).
- NACK retry: `wr_req` is low for exactly 1 cycle between attempts.
- Soft reset: `RESET_DELAY_CYC` extra cycles between the `wr_done` of 0x12 and the next FETCH.
- `finish` rises 2 cycles after the last `wr_done` (NEXT, then DONE).
- `tab_addr` changes only in NEXT or on `start`.

## Test plan
- Start with a 4-entry table {0x1180, 0x3A04, 0x40D0, 0x8C00}, `TABLE_LEN`=4, and an engine answering `wr_done` 10 cycles after `wr_req`:
  - Exactly 4 `wr_req` pulses with the matching `wr_reg`/`wr_dat`.
  - `finish`=1, `busy`=0.
  - `finish` stays 1 while `in_flag` is held high.
- Table entry 0 = 0x1280, `RESET_DELAY_CYC`=50 -> the second `wr_req` rises ≥53 cycles after the first `wr_done`.
- NACK on entry 1 twice, then ACK, `MAX_RETRY`=3 -> 3 `wr_req` pulses carrying identical data, then `finish`=1, `error`=0.
- NACK on entry 2 forever, `MAX_RETRY`=3 -> 4 attempts, then `error`=1, `err_addr`=2, `finish`=0, `busy`=0. A new `in_flag` edge restarts at entry 0 and clears `error`.
- Entry 2 = 0xFFFF with `TABLE_LEN`=16 -> only 2 writes, then `finish`=1.
- `rst` asserted low while in WAIT -> `wr_req`, `busy` and `tab_addr` read 0 before the next clock edge. After release, nothing happens until an `in_flag` edge.
